// File: rtl/ieee_float_pkg.sv
// Shared floating-point types: rounding modes and normalizer state.
// Helper packs the {guard, sticky} pair consumed by float_rounder.
package ieee_float_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } round_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    LSHIFT,
    RSHIFT,
    ZERO,
    DONE
  } norm_state_t;

  function automatic logic [1:0] pack_gs(
    input logic guard,
    input logic low_or,
    input logic acc
  );
    return {guard, low_or | acc};
  endfunction

endpackage

// File: rtl/float_normalizer.sv
// Bit-serial normalizer: left-shifts out leading zeros or right-shifts
// to denormalize below EMIN, feeding float_rounder.
module float_normalizer
  import ieee_float_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int EW   = 6,
  parameter int EMIN = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 sign_i,
  input  logic signed [EW-1:0] exp_i,
  input  logic [W-1:0]         mant_i,
  input  round_mode_t          round_mode_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sign_o,
  output logic signed [EW-1:0] exp_o,
  output logic [N-1:0]         A_o,
  output logic [1:0]           sticky_o,
  output round_mode_t          round_mode_o
);

  localparam logic signed [EW-1:0] EMIN_E = EW'(EMIN);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);

  norm_state_t          state;
  logic [W-1:0]         mant;
  logic [W-1:0]         mant_rs;
  logic signed [EW-1:0] exp_r;
  logic                 sticky_acc;
  logic                 sign_r;
  round_mode_t          rm_r;

  assign mant_rs = mant >> 1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      mant       <= '0;
      exp_r      <= '0;
      sticky_acc <= 1'b0;
      sign_r     <= 1'b0;
      rm_r       <= RNE;
      valid_o    <= 1'b0;
      ready_o    <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            sign_r     <= sign_i;
            exp_r      <= exp_i;
            mant       <= mant_i;
            rm_r       <= round_mode_i;
            sticky_acc <= 1'b0;
            ready_o    <= 1'b0;
            if (mant_i == '0)
              state <= ZERO;
            else if (exp_i < EMIN_E)
              state <= RSHIFT;
            else
              state <= LSHIFT;
          end
        end
        LSHIFT: begin
          if (mant[W-1] || exp_r == EMIN_E) begin
            state   <= DONE;
            valid_o <= 1'b1;
          end else begin
            mant  <= mant << 1;
            exp_r <= exp_r - ONE_E;
          end
        end
        RSHIFT: begin
          if (exp_r == EMIN_E) begin
            state   <= DONE;
            valid_o <= 1'b1;
          end else begin
            sticky_acc <= sticky_acc | mant[0];
            mant       <= mant_rs;
            // all significant bits gone: nothing left to denormalize
            if (mant_rs == '0) begin
              exp_r   <= EMIN_E;
              state   <= DONE;
              valid_o <= 1'b1;
            end else begin
              exp_r <= exp_r + ONE_E;
            end
          end
        end
        ZERO: begin
          exp_r      <= EMIN_E;
          sticky_acc <= 1'b0;
          state      <= DONE;
          valid_o    <= 1'b1;
        end
        DONE: begin
          if (ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A_o          = mant[W-1 -: N];
  assign sticky_o     = pack_gs(mant[W-N-1], |mant[W-N-2:0], sticky_acc);
  assign exp_o        = exp_r;
  assign sign_o       = sign_r;
  assign round_mode_o = rm_r;

endmodule

// File: tb/tb_float_normalizer.sv
// Bench for float_normalizer: directed table, corner sequences and
// randomized operands against a closed-form reference model.
module tb_float_normalizer;
  import ieee_float_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int EW = 6;
  localparam int EMIN = 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              valid_i;
  logic              ready_o;
  logic              sign_i;
  logic signed [5:0] exp_i;
  logic [7:0]        mant_i;
  round_mode_t       round_mode_i;
  logic              valid_o;
  logic              ready_i;
  logic              sign_o;
  logic signed [5:0] exp_o;
  logic [3:0]        A_o;
  logic [1:0]        sticky_o;
  round_mode_t       round_mode_o;

  float_normalizer #(.N(N), .W(W), .EW(EW), .EMIN(EMIN)) dut (
    .clock(clock), .reset_n(reset_n),
    .valid_i(valid_i), .ready_o(ready_o),
    .sign_i(sign_i), .exp_i(exp_i), .mant_i(mant_i),
    .round_mode_i(round_mode_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .sign_o(sign_o), .exp_o(exp_o), .A_o(A_o),
    .sticky_o(sticky_o), .round_mode_o(round_mode_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sign;
    int          exp;
    logic [7:0]  mant;
    round_mode_t rm;
    logic [3:0]  a;
    logic [1:0]  st;
    int          eo;
    int          lat;
  } vec_t;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Closed-form result: shift distance decided up front from the
  // leading-zero count or the distance to EMIN.
  task automatic model(input int m, input int e,
                       output int a, output int st,
                       output int eo, output int lat);
    int msb, k, mm, lost, g, s;
    lost = 0;
    if (m == 0) begin
      a = 0; st = 0; eo = EMIN; lat = 2;
      return;
    end
    msb = $clog2(m + 1) - 1;
    if (e < EMIN) begin
      k = EMIN - e;
      if (k > msb) begin
        a = 0; st = 1; eo = EMIN; lat = 1 + msb + 1;
        return;
      end
      mm = m >> k;
      lost = ((m & ((1 << k) - 1)) != 0) ? 1 : 0;
      lat = 2 + k;
      eo = EMIN;
    end else begin
      k = W - 1 - msb;
      if (e - EMIN < k) k = e - EMIN;
      mm = (m << k) & 255;
      eo = e - k;
      lat = 2 + k;
    end
    a = mm >> (W - N);
    g = (mm >> (W - N - 1)) & 1;
    s = (((mm & ((1 << (W - N - 1)) - 1)) != 0) || lost != 0) ? 1 : 0;
    st = g * 2 + s;
  endtask

  task automatic run_op(input vec_t v, input bit bp);
    int n;
    logic [3:0] a0;
    logic [1:0] s0;
    logic signed [5:0] e0;
    n = 0;
    while (!ready_o && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("ready_before_op", int'(ready_o), 1);
    sign_i = v.sign;
    exp_i = v.exp[5:0];
    mant_i = v.mant;
    round_mode_i = v.rm;
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clock); #1;
    valid_i = 1'b0;
    sign_i = ~v.sign;
    mant_i = 8'($urandom);
    exp_i = 6'($urandom);
    round_mode_i = RTZ;
    n = 0;
    while (!valid_o && n < 40) begin
      @(posedge clock); #1; n++;
    end
    check("latency", valid_o ? n + 1 : -1, v.lat);
    check("A_o", int'(A_o), int'(v.a));
    check("sticky_o", int'(sticky_o), int'(v.st));
    check("exp_o", int'(exp_o), v.eo);
    check("sign_o", int'(sign_o), int'(v.sign));
    check("round_mode_o", int'(round_mode_o), int'(v.rm));
    check("ready_o_busy", int'(ready_o), 0);
    if (bp) begin
      a0 = A_o; s0 = sticky_o; e0 = exp_o;
      for (int i = 0; i < 3; i++) begin
        valid_i = ~valid_i;
        mant_i = 8'($urandom);
        @(posedge clock); #1;
        check("bp_valid", int'(valid_o), 1);
        check("bp_ready", int'(ready_o), 0);
        check("bp_A", int'(A_o), int'(a0));
        check("bp_sticky", int'(sticky_o), int'(s0));
        check("bp_exp", int'(exp_o), int'(e0));
      end
      valid_i = 1'b0;
    end
    ready_i = 1'b1;
    @(posedge clock); #1;
    ready_i = 1'b0;
    check("valid_drop", int'(valid_o), 0);
    check("ready_back", int'(ready_o), 1);
  endtask

  vec_t tbl[6];

  initial begin
    vec_t v;
    int a, st, eo, lat, m, e;
    tbl[0] = '{1'b0, 5,   8'b1011_0110, RUP, 4'b1011, 2'b01, 5, 2};
    tbl[1] = '{1'b0, 10,  8'b0001_1010, RNE, 4'b1101, 2'b00, 7, 5};
    tbl[2] = '{1'b1, 2,   8'b0001_1010, RDN, 4'b0011, 2'b01, 1, 3};
    tbl[3] = '{1'b0, -1,  8'b1100_0001, RMM, 4'b0011, 2'b01, 1, 4};
    tbl[4] = '{1'b1, -20, 8'b0000_0001, RTZ, 4'b0000, 2'b01, 1, 2};
    tbl[5] = '{1'b1, 9,   8'b0000_0000, RUP, 4'b0000, 2'b00, 1, 2};

    reset_n = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    sign_i = 1'b0;
    exp_i = '0;
    mant_i = '0;
    round_mode_i = RNE;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", int'(valid_o), 0);
    check("rst_ready", int'(ready_o), 1);
    check("rst_A", int'(A_o), 0);
    check("rst_sticky", int'(sticky_o), 0);
    check("rst_exp", int'(exp_o), 0);
    check("rst_rm", int'(round_mode_o), int'(RNE));
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) run_op(tbl[i], i == 1);

    // reset while left-shifting
    sign_i = 1'b1;
    exp_i = 6'sd10;
    mant_i = 8'b0001_1010;
    round_mode_i = RUP;
    valid_i = 1'b1;
    @(posedge clock); #1;
    valid_i = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_ready", int'(ready_o), 1);
    check("midrst_A", int'(A_o), 0);
    check("midrst_sticky", int'(sticky_o), 0);
    check("midrst_exp", int'(exp_o), 0);
    check("midrst_sign", int'(sign_o), 0);
    check("midrst_rm", int'(round_mode_o), int'(RNE));
    repeat (6) @(posedge clock);
    #1;
    check("midrst_no_valid", int'(valid_o), 0);

    for (int i = 0; i < 200; i++) begin
      m = (($urandom & 15) == 0) ? 0 : int'($urandom_range(1, 255));
      if (($urandom & 3) == 0) m = m & 15;
      e = int'($signed(6'($urandom)));
      model(m, e, a, st, eo, lat);
      v.sign = 1'($urandom);
      v.exp = e;
      v.mant = 8'(m);
      v.rm = round_mode_t'($urandom_range(0, 4));
      v.a = 4'(a);
      v.st = 2'(st);
      v.eo = eo;
      v.lat = lat;
      run_op(v, (i % 25) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/float_normalizer.md
Name: float_normalizer

Overview:
- Multi-cycle normalizer directly upstream of float_rounder.
- Takes an unnormalized sign/exponent/wide-mantissa result from an FPU datapath (adder, multiplier, converter).
- Shifts left to remove leading zeros, or right to denormalize below EMIN, one bit per cycle.
- Emits the N-bit truncated mantissa plus the {guard, sticky} pair and the round mode exactly as float_rounder consumes them. Valid/ready handshakes on both sides.

Parameters:
- N, 4: output mantissa width fed to float_rounder A.
- W, 8: input mantissa width; W >= N+2. The hidden-bit position is W-1.
- EW, 6: exponent width, two's-complement signed.
- EMIN, 1: minimum (subnormal) biased exponent.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- valid_i  in  1  input operand valid
- ready_o  out  1  block can accept an operand
- sign_i  in  1  operand sign
- exp_i  in  EW  signed exponent
- mant_i  in  W  unnormalized mantissa
- round_mode_i  in  round_mode_t  rounding mode, passed through
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts the result
- sign_o  out  1  registered sign
- exp_o  out  EW  normalized exponent
- A_o  out  N  mant[W-1 -: N]
- sticky_o  out  2  {guard = mant[W-N-1], sticky = |mant[W-N-2:0] OR sticky_acc}
- round_mode_o  out  round_mode_t  registered round mode

Behaviour:
- Reset: synchronous while reset_n = 0 at a clock edge.
  - Resets to IDLE, including mid-operation; the in-flight operand is discarded.
  - All outputs 0 after reset, round_mode_o = RNE, ready_o = 1.
- IDLE:
  - ready_o = 1, valid_o = 0.
  - On valid_i & ready_o, capture sign, exp, mant and round_mode; clear sticky_acc.
  - Next state: ZERO if mant_i == 0; else RSHIFT if exp_i < EMIN (signed compare); else LSHIFT.
- LSHIFT, one decision per cycle:
  - If mant[W-1] == 1 or exp == EMIN: go to DONE.
  - Else mant <<= 1, exp -= 1.
- RSHIFT, one decision per cycle:
  - If exp == EMIN: go to DONE.
  - Else sticky_acc |= mant[0], mant >>= 1, exp += 1.
  - If mant becomes 0: set exp = EMIN and go to DONE immediately. This bounds latency at W+1 shift cycles.
- ZERO: exp = EMIN, sticky_acc = 0; go to DONE.
- DONE:
  - valid_o = 1; outputs are driven from the registered mant/exp/sticky_acc and held stable while ready_i = 0.
  - ready_o = 0 in every state except IDLE; valid_i is ignored outside IDLE.
  - On ready_i = 1, go to IDLE; valid_o falls the next cycle.
- Latency: 1 capture cycle + k shift cycles + 1 cycle to DONE. An already-normalized operand gives valid_o 2 cycles after acceptance.
- Throughput: one operand in flight; no input buffering.
- Arithmetic: exp uses EW-bit signed arithmetic. Left shifts stop at EMIN, so exp never underflows. Input exp overflow is the producer's responsibility.
- Zero result: A_o = 0, sticky_o = 00, exp_o = EMIN, sign preserved.

Decomposition:
- round_mode_t and the rounding-mode constants stay in ieee_float_pkg.
- Add to ieee_float_pkg: the state enum norm_state_t {IDLE, LSHIFT, RSHIFT, ZERO, DONE} and a function packing {guard, sticky} from a mantissa and sticky_acc.
- No sub-module needed. float_normalizer plus float_rounder are instantiated side by side by the datapath.

Test Plan (N=4, W=8, EW=6, EMIN=1):
- mant=1011_0110, exp=5, RUP -> valid_o 2 cycles after acceptance; A_o=1011, sticky_o=01, exp_o=5, round_mode_o=RUP.
- mant=0001_1010, exp=10 -> 3 left shifts; A_o=1101, sticky_o=00, exp_o=7, valid_o 5 cycles after acceptance.
- mant=0001_1010, exp=2 -> stops at EMIN after 1 shift; A_o=0011, sticky_o=01, exp_o=1.
- mant=1100_0001, exp=-1 -> 2 right shifts, first shifted-out bit 1; A_o=0011, sticky_o=01, exp_o=1. Also mant=0000_0001, exp=-20 -> mant reaches 0 after 1 shift; A_o=0000, sticky_o=01, exp_o=1.
- mant=0, sign=1, exp=9 -> A_o=0, sticky_o=00, exp_o=1, sign_o=1.
- Backpressure and reset:
  - Hold ready_i=0 for 3 cycles in DONE while toggling valid_i: outputs stable, ready_o=0, no new capture.
  - Assert reset_n=0 during LSHIFT: next cycle valid_o=0, ready_o=1, all outputs 0.
